risc_cpu_hs: RTL

Parametrised successor of the 8-bit accumulator RISC core: same 3-bit-opcode ISA (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP), generalised in data and address width, driven by a single FSM, and talking to memory over a variable-latency req/ready handshake instead of a fixed 8-phase clock. It is the processor top of the design. Its master port connects to the instruction/data RAM or ROM decoder.

---
 rtl/risc_cpu_hs.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/risc_cpu_hs.sv
// risc_cpu_hs: parametrised 3-bit-opcode accumulator RISC core.
// One FSM, two-beat instruction fetch, req/ready memory master port.
module risc_cpu_hs #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              start,
    output logic              halt,
    output logic              fetch,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [DATA_W-1:0] acc
);
    localparam int unsigned IW = 3 + ADDR_W;
    localparam int unsigned HW = IW - DATA_W;

    generate
        if (IW < DATA_W + 1 || IW > 2 * DATA_W) begin : g_bad_width
            $error("risc_cpu_hs: need DATA_W+1 <= 3+ADDR_W <= 2*DATA_W");
        end
    endgenerate

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH_HI,
        S_FETCH_LO,
        S_DECODE,
        S_EXEC_RD,
        S_EXEC_WR,
        S_HALTED
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [IW-1:0]     r_ir;
    logic [IW-1:0]     w_ir_next;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_acc_next;
    logic              r_run;
    logic              w_req;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_op;
    logic [ADDR_W-1:0] w_opnd;

    assign w_op   = r_ir[IW-1:ADDR_W];
    assign w_opnd = r_ir[ADDR_W-1:0];

    // r_run keeps the port quiet for the one cycle reset is being released
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_pc;
        case (r_state)
            S_FETCH_HI: w_req = r_run;
            S_FETCH_LO: begin
                w_req  = r_run;
                w_addr = r_pc + ADDR_W'(1);
            end
            S_EXEC_RD, S_EXEC_WR: begin
                w_req  = r_run;
                w_addr = w_opnd;
            end
            default: w_req = 1'b0;
        endcase
    end

    assign w_accept  = w_req & mem_ready;
    assign mem_req   = w_req;
    assign mem_we    = w_req && (r_state == S_EXEC_WR);
    assign mem_addr  = w_req ? w_addr : '0;
    assign mem_wdata = r_acc;

    always_comb begin
        w_next     = r_state;
        w_pc_next  = r_pc;
        w_ir_next  = r_ir;
        w_acc_next = r_acc;
        unique case (r_state)
            S_FETCH_HI: if (w_accept) begin
                w_ir_next[IW-1:DATA_W] = mem_rdata[HW-1:0];
                w_next = S_FETCH_LO;
            end
            S_FETCH_LO: if (w_accept) begin
                w_ir_next[DATA_W-1:0] = mem_rdata;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                w_pc_next = r_pc + ADDR_W'(2);
                unique case (w_op)
                    OP_HLT: w_next = S_HALTED;
                    OP_SKZ: begin
                        w_next = S_FETCH_HI;
                        if (r_acc == '0) w_pc_next = r_pc + ADDR_W'(4);
                    end
                    OP_JMP: begin
                        w_next    = S_FETCH_HI;
                        w_pc_next = w_opnd;
                    end
                    OP_STO:  w_next = S_EXEC_WR;
                    default: w_next = S_EXEC_RD;
                endcase
            end
            S_EXEC_RD: if (w_accept) begin
                unique case (w_op)
                    OP_ADD:  w_acc_next = r_acc + mem_rdata;
                    OP_AND:  w_acc_next = r_acc & mem_rdata;
                    OP_XOR:  w_acc_next = r_acc ^ mem_rdata;
                    OP_LDA:  w_acc_next = mem_rdata;
                    default: w_acc_next = r_acc;
                endcase
                w_next = S_FETCH_HI;
            end
            S_EXEC_WR: if (w_accept) w_next = S_FETCH_HI;
            S_HALTED:  if (start) w_next = S_FETCH_HI;
            default:   w_next = S_FETCH_HI;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH_HI;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_acc   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
            r_acc   <= w_acc_next;
            r_run   <= 1'b1;
        end
    end

    assign halt    = (r_state == S_HALTED);
    assign fetch   = r_run && (r_state == S_FETCH_HI || r_state == S_FETCH_LO);
    assign opcode  = w_op;
    assign ir_addr = w_opnd;
    assign pc_addr = r_pc;
    assign acc     = r_acc;
endmodule
